// File: rtl/quad_enc_decoder_pkg.sv
// quad_enc_decoder_pkg: quadrature phase encoding and step classification
package quad_enc_decoder_pkg;
  typedef enum logic [1:0] {PH00, PH10, PH11, PH01} qph_e;
  function automatic qph_e qph(input logic [1:0] ab);
    return qph_e'({ab[0], ab[1] ^ ab[0]});
  endfunction
  // {legal, inc, dec}; a change of both phases at once is the only illegal move
  function automatic logic [2:0] qdir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] p, c;
    p = qph(prev);
    c = qph(cur);
    return {(prev ^ cur) != 2'b11, c == p + 2'd1, p == c + 2'd1};
  endfunction
endpackage

// File: rtl/quad_enc_decoder_deb.sv
// deb_filter: synchroniser plus level filter for one encoder phase
module deb_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic din,
  output logic dout
);
  localparam int CW = FILT_CYC > 1 ? $clog2(FILT_CYC) : 1;
  localparam logic [CW-1:0] last = CW'(FILT_CYC - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic filt, s;
  assign s = sync[SYNC_STAGES-1];
  // during init the synchronised level bypasses the filter so the decoder starts at rest
  assign dout = init ? s : filt;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      filt <= (init || cnt == last) ? s : filt;
      cnt <= (init || s == filt || cnt == last) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/quad_enc_decoder.sv
// quad_enc_decoder: filtered x4 quadrature decode into signed position, step and direction
module quad_enc_decoder
  import quad_enc_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC = 16,
  parameter int CNT_W = 16,
  parameter int WRAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic clr,
  input  logic err_clr,
  output logic signed [CNT_W-1:0] pos,
  output logic step,
  output logic dir,
  output logic err
);
  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam logic signed [CNT_W-1:0] pmax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] pmin = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] one = {{(CNT_W-1){1'b0}}, 1'b1};
  logic init, fa, fb, legal, inc, dec, mv;
  logic [IW-1:0] icnt;
  logic [1:0] cur, prev;
  logic signed [CNT_W-1:0] pos_nxt;
  deb_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_deb_a (
    .clk(clk), .rst(rst), .init(init), .din(a_in), .dout(fa)
  );
  deb_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_deb_b (
    .clk(clk), .rst(rst), .init(init), .din(b_in), .dout(fb)
  );
  assign cur = {fa, fb};
  assign {legal, inc, dec} = qdir(prev, cur);
  assign mv = !init && (inc || dec);
  always_comb
    pos_nxt = clr ? '0 :
              !mv ? pos :
              inc ? ((pos == pmax && WRAP == 0) ? pos : pos + one) :
                    ((pos == pmin && WRAP == 0) ? pos : pos - one);
  always_ff @(posedge clk)
    if (rst) begin
      init <= 1'b1;
      icnt <= '0;
      prev <= '0;
      pos <= '0;
      step <= 1'b0;
      dir <= 1'b0;
      err <= 1'b0;
    end else begin
      init <= init && icnt != IW'(SYNC_STAGES);
      icnt <= init ? icnt + IW'(1) : icnt;
      prev <= cur;
      pos <= pos_nxt;
      step <= mv;
      dir <= mv ? dec : dir;
      err <= (!init && !legal) || (err && !err_clr);
    end
endmodule
